// File: rtl/char_classifier_pkg.sv
// char_classifier_pkg: ASCII code constants and class-index constants that
// fix the bit order of the classifier flag vector.
// Latency: n/a (constants only). Backpressure: n/a.
package char_classifier_pkg;

  // ASCII codes that are awkward to write as character literals
  localparam logic [7:0] ASCII_NUL    = 8'h00;
  localparam logic [7:0] ASCII_TAB    = 8'h09;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_LPAREN = 8'h28;
  localparam logic [7:0] ASCII_RPAREN = 8'h29;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_RBRACK = 8'h5D;
  localparam logic [7:0] ASCII_LBRACE = 8'h7B;
  localparam logic [7:0] ASCII_RBRACE = 8'h7D;

  // Bit positions inside the flag vector
  localparam int CLS_START_STOP   = 0;
  localparam int CLS_SMALL        = 1;
  localparam int CLS_CAPITAL      = 2;
  localparam int CLS_NUMBER       = 3;
  localparam int CLS_HEX          = 4;
  localparam int CLS_PUNCT_BASIC  = 5;
  localparam int CLS_PUNCT_FIN    = 6;
  localparam int CLS_PAREN        = 7;
  localparam int CLS_CURLY        = 8;
  localparam int CLS_MATH         = 9;
  localparam int CLS_WHITESPACE   = 10;
  localparam int CLS_VOWEL        = 11;
  localparam int CLS_CONSONANT    = 12;
  localparam int CLS_OTHER        = 13;
  localparam int NUM_CLASSES      = 14;

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous byte FIFO with occupancy count, async active-high reset.
// Latency: head byte visible combinationally the cycle after its push.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: i_push/i_push_data write side, i_pop read side, o_head_data current
//        head, o_full/o_empty status, o_count occupancy (0..DEPTH).
module char_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  // A full FIFO refuses pushes even when a pop frees a slot on the same edge.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/char_classifier.sv
// char_classifier: buffers raw bytes and emits one classified character per
// GAP cycles as a one-cycle valid pulse with registered flags and char_out.
// Latency: byte pushed into an idle, empty block appears one edge later.
// Backpressure: in_ready drops while the FIFO holds DEPTH bytes.
// Ports: in_data/in_valid/in_ready byte input; valid/char_out plus the class
//        flags describe the last popped byte; fifo_count is the occupancy.
module char_classifier
  import char_classifier_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   valid,
  output logic [7:0]             char_out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   start_stop,
  output logic                   small_letter,
  output logic                   capital_letter,
  output logic                   number,
  output logic                   hex_digit,
  output logic                   punctuation_basic,
  output logic                   punctuation_finance,
  output logic                   parentheses,
  output logic                   curly_braces,
  output logic                   math_symbol,
  output logic                   whitespace,
  output logic                   vowel,
  output logic                   consonant,
  output logic                   other
);
  localparam int              PW        = $clog2(GAP + 1);
  localparam logic [PW-1:0]   PACE_LOAD = PW'(GAP - 1);

  logic [7:0]             w_head;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [NUM_CLASSES-1:0] w_cls;

  logic                   r_valid;
  logic [7:0]             r_char;
  logic [NUM_CLASSES-1:0] r_flags;
  logic [PW-1:0]          r_pace;

  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = !w_empty && (r_pace == '0);

  char_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (in_data),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  // Classification of the FIFO head; only sampled into r_flags on a pop.
  always_comb begin
    w_cls = '0;
    w_cls[CLS_START_STOP]  = (w_head == ASCII_NUL);
    w_cls[CLS_SMALL]       = (w_head inside {[8'h61:8'h7A]});
    w_cls[CLS_CAPITAL]     = (w_head inside {[8'h41:8'h5A]});
    w_cls[CLS_NUMBER]      = (w_head inside {[8'h30:8'h39]});
    w_cls[CLS_HEX]         = (w_head inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]});
    w_cls[CLS_PUNCT_BASIC] = (w_head inside {".", ",", ":", ";", "!", "?", "'", "\""});
    w_cls[CLS_PUNCT_FIN]   = (w_head inside {"#", "$", "%", "&", "@"});
    w_cls[CLS_PAREN]       = (w_head inside {ASCII_LPAREN, ASCII_RPAREN, ASCII_LBRACK, ASCII_RBRACK});
    w_cls[CLS_CURLY]       = (w_head inside {ASCII_LBRACE, ASCII_RBRACE});
    w_cls[CLS_MATH]        = (w_head inside {"+", "-", "*", "/", "\\", "=", "<", ">"});
    w_cls[CLS_WHITESPACE]  = (w_head inside {ASCII_SPACE, ASCII_TAB, ASCII_LF, ASCII_CR});
    w_cls[CLS_VOWEL]       = (w_head inside {"a", "e", "i", "o", "u", "A", "E", "I", "O", "U"});
    w_cls[CLS_CONSONANT]   = (w_cls[CLS_SMALL] || w_cls[CLS_CAPITAL]) && !w_cls[CLS_VOWEL];
    // hex, vowel and consonant only ever refine a class already in this list
    w_cls[CLS_OTHER]       = !(w_cls[CLS_START_STOP] || w_cls[CLS_SMALL] || w_cls[CLS_CAPITAL] ||
                               w_cls[CLS_NUMBER] || w_cls[CLS_PUNCT_BASIC] || w_cls[CLS_PUNCT_FIN] ||
                               w_cls[CLS_PAREN] || w_cls[CLS_CURLY] || w_cls[CLS_MATH] ||
                               w_cls[CLS_WHITESPACE]);
  end

  // The pacer reloads on every pop so consecutive pulses are GAP cycles apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_char  <= '0;
      r_flags <= '0;
      r_pace  <= '0;
    end else begin
      r_valid <= w_pop;
      if (w_pop) begin
        r_char  <= w_head;
        r_flags <= w_cls;
        r_pace  <= PACE_LOAD;
      end else if (r_pace != '0) begin
        r_pace  <= r_pace - 1'b1;
      end
    end
  end

  assign valid               = r_valid;
  assign char_out            = r_char;
  assign start_stop          = r_flags[CLS_START_STOP];
  assign small_letter        = r_flags[CLS_SMALL];
  assign capital_letter      = r_flags[CLS_CAPITAL];
  assign number              = r_flags[CLS_NUMBER];
  assign hex_digit           = r_flags[CLS_HEX];
  assign punctuation_basic   = r_flags[CLS_PUNCT_BASIC];
  assign punctuation_finance = r_flags[CLS_PUNCT_FIN];
  assign parentheses         = r_flags[CLS_PAREN];
  assign curly_braces        = r_flags[CLS_CURLY];
  assign math_symbol         = r_flags[CLS_MATH];
  assign whitespace          = r_flags[CLS_WHITESPACE];
  assign vowel               = r_flags[CLS_VOWEL];
  assign consonant           = r_flags[CLS_CONSONANT];
  assign other               = r_flags[CLS_OTHER];

endmodule

// File: tb/tb_char_classifier.sv
// tb_char_classifier: self-checking bench for char_classifier (DEPTH=8, GAP=3).
// Reference keeps a byte queue and pops at the earliest edge that is at least
// GAP edges after the previous pop; classes come from character-set lookups.
module tb_char_classifier;
  localparam int DEPTH = 8;
  localparam int GAP   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       valid;
  logic [7:0] char_out;
  logic [3:0] fifo_count;
  logic start_stop, small_letter, capital_letter, number, hex_digit;
  logic punctuation_basic, punctuation_finance, parentheses, curly_braces;
  logic math_symbol, whitespace, vowel, consonant, other;

  always #5 clk = ~clk;

  char_classifier #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .valid(valid), .char_out(char_out), .fifo_count(fifo_count),
    .start_stop(start_stop), .small_letter(small_letter), .capital_letter(capital_letter),
    .number(number), .hex_digit(hex_digit), .punctuation_basic(punctuation_basic),
    .punctuation_finance(punctuation_finance), .parentheses(parentheses),
    .curly_braces(curly_braces), .math_symbol(math_symbol), .whitespace(whitespace),
    .vowel(vowel), .consonant(consonant), .other(other)
  );

  wire [13:0] dut_flags = {other, consonant, vowel, whitespace, math_symbol, curly_braces,
                           parentheses, punctuation_finance, punctuation_basic, hex_digit,
                           number, capital_letter, small_letter, start_stop};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_set(input string s, input logic [7:0] c);
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Flag order (bit 0 upward): start_stop, small, capital, number, hex,
  // punct_basic, punct_finance, parentheses, curly, math, whitespace,
  // vowel, consonant, other.
  function automatic logic [13:0] ref_cls(input logic [7:0] c);
    bit ss, sm, cp, nm, hx, pb, pf, pa, cb, ms, ws, vw, cn, ot;
    ss = (c == 8'd0);
    sm = in_set("abcdefghijklmnopqrstuvwxyz", c);
    cp = in_set("ABCDEFGHIJKLMNOPQRSTUVWXYZ", c);
    nm = in_set("0123456789", c);
    hx = in_set("0123456789ABCDEFabcdef", c);
    pb = in_set(".,:;!?'\"", c);
    pf = in_set("#$%&@", c);
    pa = in_set("()[]", c);
    cb = in_set("{}", c);
    ms = in_set("+-*/\\=<>", c);
    ws = (c == 8'd32) || (c == 8'd9) || (c == 8'd10) || (c == 8'd13);
    vw = in_set("aeiouAEIOU", c);
    cn = (sm || cp) && !vw;
    ot = !(ss || sm || cp || nm || pb || pf || pa || cb || ms || ws);
    return {ot, cn, vw, ws, ms, cb, pa, pf, pb, hx, nm, cp, sm, ss};
  endfunction

  // Reference state
  logic [7:0]  q[$];
  int          t = 0;
  int          last_pop = -100;
  logic [7:0]  exp_char = 8'h00;
  logic [13:0] exp_flags = '0;
  int          n_pulses = 0;
  bit          saw_full = 1'b0;

  task automatic model_reset();
    q.delete();
    last_pop  = -100;
    exp_char  = 8'h00;
    exp_flags = '0;
  endtask

  // One clock cycle: drive at negedge, check in_ready, then check outputs
  // 1 time unit after the rising edge against the reference.
  task automatic cycle(input logic v, input logic [7:0] d, output bit acc);
    bit pop;
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    #1;
    chk("in_ready", in_ready, (q.size() != DEPTH));
    acc = v && (q.size() != DEPTH);
    @(posedge clk);
    t++;
    #1;
    pop = (q.size() > 0) && ((t - last_pop) >= GAP);
    if (pop) begin
      exp_char  = q.pop_front();
      exp_flags = ref_cls(exp_char);
      last_pop  = t;
    end
    chk("valid", valid, pop);
    chk("char_out", char_out, exp_char);
    chk("flags", dut_flags, exp_flags);
    if (acc) q.push_back(d);
    chk("fifo_count", fifo_count, q.size());
    if (fifo_count == 4'(DEPTH)) saw_full = 1'b1;
    if (valid) n_pulses++;
  endtask

  task automatic push_byte(input logic [7:0] d);
    bit acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) cycle(1'b1, d, acc);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, acc);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_char", char_out, 0);
    chk("rst_flags", dut_flags, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    string pool;
    pool = "{}()[]aZ~0F9x .,#$+-\\<@Eq:";
    if ($urandom_range(3) == 0) return 8'($urandom_range(255));
    return pool[$urandom_range(pool.len() - 1)];
  endfunction

  initial begin
    string burst;
    string multi;
    int    p0;
    bit    acc;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #3;
    chk("init_in_ready", in_ready, 1);
    chk("init_valid", valid, 0);
    chk("init_count", fifo_count, 0);
    chk("init_flags", dut_flags, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single byte into an idle block
    push_byte(8'h7B);
    idle(4);

    // Paced burst terminated by NUL: expect 12 pulses, GAP apart
    burst = "{1A3F+00ff}";
    p0 = n_pulses;
    for (int i = 0; i < burst.len(); i++) push_byte(burst[i]);
    push_byte(8'h00);
    idle(40);
    chk("burst_pulses", n_pulses - p0, 12);

    // Multi-class bytes
    multi = "aZ~";
    for (int i = 0; i < multi.len(); i++) push_byte(multi[i]);
    idle(12);

    // Backpressure: continuous in_valid until well past full, then drain
    saw_full = 1'b0;
    p0 = n_pulses;
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'(8'h41 + i), acc);
    chk("saw_full", saw_full, 1);
    idle(40);
    chk("drain_empty", fifo_count, 0);

    // Reset with 5 bytes buffered
    for (int k = 0; k < 40 && q.size() < 5; k++) cycle(1'b1, pick_byte(), acc);
    chk("mid_q5", q.size(), 5);
    reset_mid();
    p0 = n_pulses;
    idle(10);
    chk("post_rst_pulses", n_pulses - p0, 0);
    push_byte("Q");
    idle(5);

    // Randomised traffic
    for (int i = 0; i < 400; i++) cycle(($urandom_range(2) != 0), pick_byte(), acc);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
